// File: rtl/slc3_pkg.sv
// Shared SLC-3 datapath definitions: branch unit FSM states, the BR opcode,
// and the 9-bit offset sign extension also used by the ADDR2 mux.
package slc3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        TARGET = 2'd2,
        COMMIT = 2'd3
    } br_state_t;

    localparam logic [3:0] OP_BR = 4'b0000;

    function automatic logic [15:0] sext9(input logic [8:0] field);
        return {{7{field[8]}}, field};
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Multi-cycle LC-3 BR resolution: capture, evaluate the condition, add the
// offset, then issue a one-cycle PC load. Also counts taken branches.
module branch_unit
    import slc3_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [15:0]      IR_In,
    input  logic [2:0]       NZP_In,
    input  logic [15:0]      PC_In,
    output logic             Busy,
    output logic             Done,
    output logic             PC_Load,
    output logic [15:0]      PC_Out,
    output logic             Taken,
    output logic [CNT_W-1:0] Taken_Count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    br_state_t        state;
    logic [15:0]      ir;
    logic [15:0]      pc;
    logic [2:0]       nzp;
    logic             cond;
    logic [15:0]      target;
    logic             taken_r;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ir      <= '0;
            pc      <= '0;
            nzp     <= '0;
            cond    <= 1'b0;
            target  <= '0;
            taken_r <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        ir    <= IR_In;
                        nzp   <= NZP_In;
                        pc    <= PC_In;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    cond  <= (ir[15:12] == OP_BR) && (|(ir[11:9] & nzp));
                    state <= TARGET;
                end
                TARGET: begin
                    target  <= pc + sext9(ir[8:0]);
                    taken_r <= cond;
                    state   <= COMMIT;
                end
                COMMIT: begin
                    // Saturate rather than wrap so a long run still reads as "many".
                    if (cond && !(&cnt))
                        cnt <= cnt + CNT_ONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy        = (state != IDLE);
    assign Done        = (state == COMMIT);
    assign PC_Load     = (state == COMMIT) && cond;
    // Built from registers only; stable from COMMIT until the next accept.
    assign PC_Out      = taken_r ? target : pc;
    assign Taken       = taken_r;
    assign Taken_Count = cnt;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a default-width instance plus a 2-bit
// counter instance sharing stimulus, for the saturation case.
module tb_branch_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] IR_In;
    logic [2:0]  NZP_In;
    logic [15:0] PC_In;

    logic        Busy, Done, PC_Load, Taken;
    logic [15:0] PC_Out;
    logic [7:0]  Taken_Count;

    logic        s_busy, s_done, s_pc_load, s_taken;
    logic [15:0] s_pc_out;
    logic [1:0]  s_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int exp_sat = 0;

    branch_unit #(.CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .IR_In(IR_In), .NZP_In(NZP_In), .PC_In(PC_In),
        .Busy(Busy), .Done(Done), .PC_Load(PC_Load),
        .PC_Out(PC_Out), .Taken(Taken), .Taken_Count(Taken_Count)
    );

    branch_unit #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .IR_In(IR_In), .NZP_In(NZP_In), .PC_In(PC_In),
        .Busy(s_busy), .Done(s_done), .PC_Load(s_pc_load),
        .PC_Out(s_pc_out), .Taken(s_taken), .Taken_Count(s_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bump(input bit tk);
        if (tk) begin
            if (exp_cnt < 255) exp_cnt++;
            if (exp_sat < 3) exp_sat++;
        end
    endtask

    // Called at #1 after a rising edge with the DUT in IDLE.
    task automatic run(input logic [15:0] ir_v, input logic [2:0] nzp_v,
                       input logic [15:0] pc_v, input bit tk, input logic [15:0] npc);
        IR_In = ir_v; NZP_In = nzp_v; PC_In = pc_v; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        IR_In = 16'($urandom); NZP_In = 3'($urandom); PC_In = 16'($urandom);
        chk("busy_eval", 32'(Busy), 32'd1);
        chk("done_eval", 32'(Done), 32'd0);
        @(posedge Clk); #1;
        chk("done_target", 32'(Done), 32'd0);
        chk("load_target", 32'(PC_Load), 32'd0);
        @(posedge Clk); #1;
        chk("done_commit", 32'(Done), 32'd1);
        chk("load_commit", 32'(PC_Load), 32'(tk));
        chk("pc_out_commit", 32'(PC_Out), 32'(npc));
        chk("taken_commit", 32'(Taken), 32'(tk));
        chk("cnt_commit", 32'(Taken_Count), 32'(exp_cnt));
        bump(tk);
        @(posedge Clk); #1;
        chk("done_idle", 32'(Done), 32'd0);
        chk("busy_idle", 32'(Busy), 32'd0);
        chk("load_idle", 32'(PC_Load), 32'd0);
        chk("pc_out_held", 32'(PC_Out), 32'(npc));
        chk("cnt_after", 32'(Taken_Count), 32'(exp_cnt));
        chk("sat_cnt_after", 32'(s_count), 32'(exp_sat));
    endtask

    initial begin
        int n_done;
        int seen;
        Reset = 1'b1; Start = 1'b0; IR_In = '0; NZP_In = '0; PC_In = '0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_load", 32'(PC_Load), 32'd0);
        chk("rst_pc_out", 32'(PC_Out), 32'h0000);
        chk("rst_taken", 32'(Taken), 32'd0);
        chk("rst_cnt", 32'(Taken_Count), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        run(16'h0C05, 3'b010, 16'h3001, 1'b1, 16'h3006);  // BRnz +5, Z set
        run(16'h0A05, 3'b010, 16'h3001, 1'b0, 16'h3001);  // BRnp +5, Z set
        run(16'h03FD, 3'b100, 16'h3010, 1'b0, 16'h3010);  // BRp -3, N set
        run(16'h0FFF, 3'b001, 16'h0000, 1'b1, 16'hFFFF);  // wrap below zero
        run(16'h1E3F, 3'b100, 16'h4000, 1'b0, 16'h4000);  // ADD, not a branch
        run(16'h0005, 3'b111, 16'h2000, 1'b0, 16'h2000);  // NOP field
        run(16'h0E10, 3'b000, 16'h5000, 1'b0, 16'h5000);  // NZP reset value
        run(16'h0E10, 3'b100, 16'h5000, 1'b1, 16'h5010);

        // Start held high across a whole resolution and beyond.
        IR_In = 16'h0C05; NZP_In = 3'b010; PC_In = 16'h3001; Start = 1'b1;
        n_done = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk); #1;
            if (i == 1) begin IR_In = 16'h0FFF; NZP_In = 3'b001; PC_In = 16'h0000; end
            if (i == 6) Start = 1'b0;
            if (i <= 4 && Done) n_done++;
            if (i == 3) begin
                chk("hold_a_pc_out", 32'(PC_Out), 32'h3006);
                chk("hold_a_taken", 32'(Taken), 32'd1);
                bump(1'b1);
            end
            if (i == 4) chk("hold_idle_gap", 32'(Busy), 32'd0);
            if (i == 5) chk("hold_reaccept", 32'(Busy), 32'd1);
            if (i == 7) begin
                chk("hold_b_done", 32'(Done), 32'd1);
                chk("hold_b_pc_out", 32'(PC_Out), 32'hFFFF);
                chk("hold_b_taken", 32'(Taken), 32'd1);
                bump(1'b1);
            end
        end
        chk("hold_single_done", 32'(n_done), 32'd1);
        chk("hold_cnt", 32'(Taken_Count), 32'(exp_cnt));

        // Reset while in EVAL aborts the resolution.
        IR_In = 16'h0C05; NZP_In = 3'b010; PC_In = 16'h3001; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("pre_rst_busy", 32'(Busy), 32'd1);
        chk("pre_rst_cnt", 32'(Taken_Count), 32'(exp_cnt));
        Reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_done", 32'(Done), 32'd0);
        chk("midrst_cnt", 32'(Taken_Count), 32'd0);
        chk("midrst_pc_out", 32'(PC_Out), 32'h0000);
        exp_cnt = 0; exp_sat = 0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (Done || PC_Load || Busy) seen++;
        end
        chk("midrst_no_pulse", 32'(seen), 32'd0);
        run(16'h0E10, 3'b100, 16'h5000, 1'b1, 16'h5010);

        // 2-bit counter saturation: 1, 2, 3, 3, 3.
        Reset = 1'b1; #1;
        exp_cnt = 0; exp_sat = 0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        for (int i = 0; i < 5; i++)
            run(16'h0E01, 3'b001, 16'h1000, 1'b1, 16'h1001);
        chk("sat_final", 32'(s_count), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
